stack_cmd_frontend: RTL and testbench
=====================================

// Module: stack_cmd_frontend
// PURPOSE
//  Upstream command stage for the 4-bit LIFO stack. Takes raw push/pop push-buttons
//  and the data switches, then synchronises and debounces the buttons. Each clean
//  press becomes exactly one command, presented on a valid/ready handshake that the
//  stack consumes on its slow enable. Replaces the direct rw-switch drive, so a
//  single press can never issue repeated pushes or pops.
// PARAMETERS
//  DW          4          data width of sw_data / cmd_data
//  DB_CYCLES   1000000    consecutive stable clk cycles needed to accept a button level change
//  CNT_W       20         debounce counter width; must hold DB_CYCLES
//  SYNC_STAGES 2          flip-flop synchroniser depth per button (>=2)
// PORTS
//  clk         in   1    system clock
//  rst         in   1    reset, synchronous, active-high
//  btn_push    in   1    raw push button, asynchronous, active-high
//  btn_pop     in   1    raw pop button, asynchronous, active-high
//  sw_data     in   DW   data switches; sampled at push press
//  cmd_valid   out  1    command pending
//  cmd_rw      out  1    1 = push, 0 = pop; stable while cmd_valid
//  cmd_data    out  DW   push data; stable while cmd_valid; 0 for pop
//  cmd_ready   in   1    consumer accepts when cmd_valid & cmd_ready at posedge clk
//  conflict    out  1    1-cycle pulse: push and pop presses in the same cycle
//  drop_cnt    out  4    count of presses discarded while busy; saturates at 15
//  busy        out  1    state != IDLE (drives LED)
// BEHAVIOUR
//  Reset: all sync flops, stable levels, counters = 0; state IDLE;
//   cmd_valid=0, cmd_rw=0, cmd_data=0, conflict=0, drop_cnt=0, busy=0.
//   rst mid-handshake abandons the pending command; no ack is required.
//  Sync: each button passes through SYNC_STAGES flops; s_x = last stage.
//  Debounce, per button: while s_x == stable_x, cnt_x = 0.
//   While they differ, cnt_x increments each cycle.
//   When cnt_x reaches DB_CYCLES-1 and they still differ, stable_x <= s_x and cnt_x <= 0.
//   Any bounce back to stable_x restarts the count from 0.
//  press_x = 1-cycle pulse on a 0->1 transition of stable_x. Releases generate nothing.
//  Latency: raw edge -> cmd_valid high = SYNC_STAGES + DB_CYCLES + 1 clk (bounce-free input).
//  FSM states IDLE, HOLD, WAIT_REL:
//   IDLE, exactly one press_x -> HOLD. Same edge loads cmd_valid=1 and cmd_rw (push=1).
//    A push loads cmd_data = sw_data from that cycle; a pop loads cmd_data = 0.
//   IDLE, press_push & press_pop together -> WAIT_REL. conflict=1 for that cycle; no command.
//   HOLD, cmd_ready=1 -> WAIT_REL. cmd_valid=0 next cycle.
//    cmd_rw and cmd_data hold their values until the next load.
//   HOLD, cmd_ready=0 -> stay. Outputs stay frozen; sw_data changes are ignored.
//   WAIT_REL, stable_push=0 & stable_pop=0 -> IDLE. Otherwise stay.
//  Any press_x while in HOLD or WAIT_REL is discarded and increments drop_cnt (sat 15).
//   Two presses in one such cycle still count +1. A conflict in IDLE is not counted as a drop.
//  Exactly one command is issued per accepted press; there is no auto-repeat while held.
//  busy = (state != IDLE), registered with the state.
// TESTING (sim with DB_CYCLES=4, SYNC_STAGES=2)
//  1 rst high 3 cycles, then low -> every output 0, busy=0.
//  2 sw_data=4'hA; btn_push 0->1, held clean; cmd_ready=1 -> cmd_valid high exactly 7 clk
//    after the edge for 1 cycle, with cmd_rw=1 and cmd_data=4'hA.
//    busy stays 1 until release is debounced.
//  3 btn_pop toggles 1,0,1 at 1-cycle spacing, then holds 1 -> exactly one pop command (cmd_rw=0).
//    drop_cnt stays 0.
//  4 cmd_ready=0 during a push; change sw_data to 4'h3 -> cmd_valid, cmd_rw and cmd_data=4'hA
//    held stable. Raise cmd_ready -> accepted in 1 cycle.
//  5 Both buttons driven high in the same cycle -> one conflict pulse, no cmd_valid,
//    busy=1 until both are released.
//  6 Push held with cmd_ready=0; pop pressed 18 times -> drop_cnt=15 (saturated).
//    rst -> drop_cnt=0 and cmd_valid=0.

Source files
------------

// File: rtl/stack_cmd_frontend.sv
// rtl/stack_cmd_frontend.sv - button synchroniser/debouncer turning each clean press into one stack command
// Push/pop buttons are synchronised, debounced and edge-detected; a small FSM presents one command per press.
module stack_cmd_frontend #(
    parameter int DW          = 4,
    parameter int DB_CYCLES   = 1000000,
    parameter int CNT_W       = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_push,
    input  logic          btn_pop,
    input  logic [DW-1:0] sw_data,
    output logic          cmd_valid,
    output logic          cmd_rw,
    output logic [DW-1:0] cmd_data,
    input  logic          cmd_ready,
    output logic          conflict,
    output logic [3:0]    drop_cnt,
    output logic          busy
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync_push;
    logic [SYNC_STAGES-1:0] r_sync_pop;
    logic [1:0]             w_sync;
    logic [1:0]             r_stable;
    logic [1:0]             r_stable_d;
    logic [1:0]             w_press;
    logic [CNT_W-1:0]       r_cnt [2];

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_load;
    logic                   w_conflict;
    logic                   w_drop;

    logic                   r_cmd_valid;
    logic                   r_cmd_rw;
    logic [DW-1:0]          r_cmd_data;
    logic                   r_conflict;
    logic [3:0]             r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_push <= '0;
            r_sync_pop  <= '0;
        end else begin
            r_sync_push <= {r_sync_push[SYNC_STAGES-2:0], btn_push};
            r_sync_pop  <= {r_sync_pop[SYNC_STAGES-2:0], btn_pop};
        end
    end

    // Index 0 is the push button, index 1 the pop button.
    assign w_sync  = {r_sync_pop[SYNC_STAGES-1], r_sync_push[SYNC_STAGES-1]};
    assign w_press = r_stable & ~r_stable_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable   <= '0;
            r_stable_d <= '0;
            r_cnt[0]   <= '0;
            r_cnt[1]   <= '0;
        end else begin
            r_stable_d <= r_stable;
            for (int i = 0; i < 2; i++) begin
                if (w_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_stable[i] <= w_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_conflict = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press[0] && w_press[1]) begin
                    w_next     = WAIT_REL;
                    w_conflict = 1'b1;
                end else if (w_press[0] || w_press[1]) begin
                    w_next = HOLD;
                    w_load = 1'b1;
                end
            end
            HOLD: begin
                w_drop = |w_press;
                if (cmd_ready) begin
                    w_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                w_drop = |w_press;
                if (r_stable == 2'b00) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_valid <= 1'b0;
            r_cmd_rw    <= 1'b0;
            r_cmd_data  <= '0;
            r_conflict  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            // The command is pending exactly while the FSM sits in HOLD.
            r_cmd_valid <= (w_next == HOLD);
            r_conflict  <= w_conflict;
            if (w_load) begin
                r_cmd_rw   <= w_press[0];
                r_cmd_data <= w_press[0] ? sw_data : '0;
            end
            if (w_drop && (r_drop_cnt != 4'd15)) begin
                r_drop_cnt <= r_drop_cnt + 4'd1;
            end
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_rw    = r_cmd_rw;
    assign cmd_data  = r_cmd_data;
    assign conflict  = r_conflict;
    assign drop_cnt  = r_drop_cnt;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_stack_cmd_frontend.sv
// tb/tb_stack_cmd_frontend.sv - directed self-checking bench for stack_cmd_frontend
// Runs with DB_CYCLES=4, SYNC_STAGES=2 so a press takes 7 clk from raw edge to cmd_valid.
module tb_stack_cmd_frontend;

    localparam int DW = 4;

    logic          clk;
    logic          rst;
    logic          btn_push;
    logic          btn_pop;
    logic [DW-1:0] sw_data;
    logic          cmd_valid;
    logic          cmd_rw;
    logic [DW-1:0] cmd_data;
    logic          cmd_ready;
    logic          conflict;
    logic [3:0]    drop_cnt;
    logic          busy;

    int n_checks = 0;
    int n_fails  = 0;

    int          m_acc   = 0;
    int          m_conf  = 0;
    int          m_vcyc  = 0;
    logic        m_rw    = 1'b0;
    logic [3:0]  m_data  = 4'h0;

    stack_cmd_frontend #(
        .DW(DW),
        .DB_CYCLES(4),
        .CNT_W(3),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_push(btn_push),
        .btn_pop(btn_pop),
        .sw_data(sw_data),
        .cmd_valid(cmd_valid),
        .cmd_rw(cmd_rw),
        .cmd_data(cmd_data),
        .cmd_ready(cmd_ready),
        .conflict(conflict),
        .drop_cnt(drop_cnt),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake/conflict observer; the stimulus takes snapshots and compares differences.
    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            m_acc  = m_acc + 1;
            m_rw   = cmd_rw;
            m_data = cmd_data;
        end
        if (conflict) m_conf = m_conf + 1;
        if (cmd_valid) m_vcyc = m_vcyc + 1;
    end

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int waited;
        waited = 0;
        while (!cmd_valid && waited < max_cyc) begin
            tick(1);
            waited++;
        end
        check_eq(tag, cmd_valid, 1);
    endtask

    int          valid_at;
    int          vcount;
    logic        cap_rw;
    logic [3:0]  cap_data;
    int          acc0;
    int          conf0;
    int          vcyc0;

    initial begin
        rst       = 1'b1;
        btn_push  = 1'b0;
        btn_pop   = 1'b0;
        sw_data   = 4'h0;
        cmd_ready = 1'b0;

        // 1: reset
        tick(3);
        rst = 1'b0;
        tick(1);
        check_eq("rst_valid", cmd_valid, 0);
        check_eq("rst_rw", cmd_rw, 0);
        check_eq("rst_data", cmd_data, 0);
        check_eq("rst_conflict", conflict, 0);
        check_eq("rst_drop", drop_cnt, 0);
        check_eq("rst_busy", busy, 0);

        // 2: clean push, latency and single-cycle command
        sw_data   = 4'hA;
        cmd_ready = 1'b1;
        btn_push  = 1'b1;
        valid_at  = 0;
        vcount    = 0;
        cap_rw    = 1'b0;
        cap_data  = 4'h0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (cmd_valid) begin
                vcount++;
                if (valid_at == 0) begin
                    valid_at = k;
                    cap_rw   = cmd_rw;
                    cap_data = cmd_data;
                end
            end
        end
        check_eq("push_latency", valid_at, 7);
        check_eq("push_valid_cycles", vcount, 1);
        check_eq("push_rw", cap_rw, 1);
        check_eq("push_data", cap_data, 4'hA);
        check_eq("push_busy_held", busy, 1);
        btn_push = 1'b0;
        tick(5);
        check_eq("push_busy_rel_early", busy, 1);
        tick(3);
        check_eq("push_busy_rel_done", busy, 0);

        // 3: bouncing pop gives exactly one pop command
        acc0    = m_acc;
        btn_pop = 1'b1;
        tick(1);
        btn_pop = 1'b0;
        tick(1);
        btn_pop = 1'b1;
        tick(20);
        check_eq("bounce_cmd_count", m_acc - acc0, 1);
        check_eq("bounce_rw", m_rw, 0);
        check_eq("bounce_data", m_data, 0);
        check_eq("bounce_drop", drop_cnt, 0);
        btn_pop = 1'b0;
        tick(10);
        check_eq("bounce_idle", busy, 0);

        // 4: backpressure freezes the command
        cmd_ready = 1'b0;
        sw_data   = 4'hA;
        btn_push  = 1'b1;
        wait_valid("bp_wait_valid", 20);
        sw_data = 4'h3;
        tick(5);
        check_eq("bp_valid_held", cmd_valid, 1);
        check_eq("bp_rw_held", cmd_rw, 1);
        check_eq("bp_data_held", cmd_data, 4'hA);
        cmd_ready = 1'b1;
        tick(1);
        check_eq("bp_accepted", cmd_valid, 0);
        check_eq("bp_data_after", cmd_data, 4'hA);
        btn_push = 1'b0;
        tick(10);
        check_eq("bp_idle", busy, 0);

        // 5: simultaneous presses
        conf0    = m_conf;
        vcyc0    = m_vcyc;
        btn_push = 1'b1;
        btn_pop  = 1'b1;
        tick(15);
        check_eq("conf_pulses", m_conf - conf0, 1);
        check_eq("conf_no_cmd", m_vcyc - vcyc0, 0);
        check_eq("conf_busy", busy, 1);
        check_eq("conf_drop", drop_cnt, 0);
        btn_push = 1'b0;
        tick(10);
        check_eq("conf_busy_pop_held", busy, 1);
        btn_pop = 1'b0;
        tick(10);
        check_eq("conf_idle", busy, 0);

        // 6: drop counter saturation, then reset
        cmd_ready = 1'b0;
        btn_push  = 1'b1;
        wait_valid("drop_wait_valid", 20);
        for (int i = 0; i < 18; i++) begin
            btn_pop = 1'b1;
            tick(8);
            btn_pop = 1'b0;
            tick(8);
            if (i == 2) check_eq("drop_after_3", drop_cnt, 3);
        end
        check_eq("drop_saturated", drop_cnt, 15);
        check_eq("drop_valid_held", cmd_valid, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check_eq("drop_rst_cnt", drop_cnt, 0);
        check_eq("drop_rst_valid", cmd_valid, 0);
        btn_push = 1'b0;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
